tlp_header_assembler: RTL and testbench
=======================================

Name: tlp_header_assembler

Overview:
- Upstream neighbour of the header sorter.
- Receives the PCIe receive DW stream (32 bit/cycle, sop/eop framed) and gathers each TLP's 3DW or 4DW header into one 128-bit word, together with the first payload DW.
- Checks framing against the fmt and length fields, then presents one complete TLP descriptor per packet to the sorter under a valid/accept handshake.
- Applies backpressure to the receive stream while a descriptor waits for acceptance.

Parameters:
- DROP_CNT_WIDTH, 8: width of the saturating dropped-packet counter.
- PAD_DW, 32'h00000000: value placed in header DW3 for 3DW headers, and in out_payload when there is no payload.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx_data  in  32  receive DW.
- rx_valid  in  1  rx_data valid this cycle.
- rx_sop  in  1  first DW of TLP (qualified by rx_valid).
- rx_eop  in  1  last DW of TLP (qualified by rx_valid).
- rx_ready  out  1  block accepts a DW this cycle; a transfer occurs when rx_valid and rx_ready are both high.
- out_header  out  128  DW0 at [31:0], DW1 at [63:32], DW2 at [95:64], DW3 at [127:96].
- out_payload  out  32  first payload DW, or PAD_DW.
- out_has_payload  out  1  fmt[1] (DW0 bit 30).
- out_hdr_4dw  out  1  fmt[0] (DW0 bit 29).
- out_valid  out  1  descriptor valid; connects to the sorter's in_data_header/in_data_payload path.
- out_accept  in  1  sorter takes the descriptor (driven from sorter ready).
- err_malformed  out  1  one-cycle pulse when a packet is dropped.
- drop_count  out  DROP_CNT_WIDTH  saturating count of dropped packets.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE.
  - out_valid=0, out_header=0, out_payload=0, out_has_payload=0, out_hdr_4dw=0.
  - err_malformed=0, drop_count=0.
  - rx_ready=0 during the reset cycle, 1 in the first cycle after reset releases.
  - Reset mid-packet or mid-HOLD discards everything; no error is counted.
- States: IDLE, HDR, PAY, DRAIN, HOLD. rx_ready=1 in every state except HOLD.
- IDLE:
  - A transfer with rx_sop stores DW0, sets hdr_dw = 4 if DW0[29] else 3, and sets len = DW0[9:0] (0 means 1024, 11-bit counter).
  - It then goes to HDR with dw_idx=1.
  - A transfer without rx_sop is silently discarded (not counted).
- HDR:
  - Each transfer stores into header slot dw_idx.
  - On the final header DW: if has_payload, go to PAY; otherwise the DW must carry eop, in which case go to HOLD.
- PAY: the first transfer stores out_payload. If len==1 it must carry eop, then go to HOLD. Otherwise go to DRAIN with remaining=len-1.
- DRAIN: transfers are discarded and remaining is decremented. eop must coincide with remaining==1, then go to HOLD.
- Malformed conditions:
  - eop earlier or later than the expected count hdr_dw + (has_payload ? len : 0).
  - rx_sop in HDR, PAY or DRAIN.
- Malformed response:
  - Pulse err_malformed for 1 cycle and increment drop_count (holding at all-ones).
  - No out_valid is produced.
  - On an eop mismatch the block returns to IDLE. If the mismatch is "no eop at the expected last DW", it then discards DWs until eop.
  - On an unexpected sop, that DW is taken as DW0 of a new packet (go to HDR).
- HOLD:
  - out_valid=1; all out_* fields are stable and registered.
  - 3DW headers have DW3=PAD_DW. Non-payload packets have out_payload=PAD_DW.
  - Latency: out_valid rises the cycle after the eop transfer.
  - On out_accept=1 (same cycle allowed): out_valid=0 next cycle, state IDLE, and a sop may be taken in that cycle.
- out_accept is ignored outside HOLD.
- Fields not written in the current packet are cleared on sop, so no stale data leaks between packets.

Test Plan:
- CfgRd0 3DW:
  - Stimulus: DWs 048FC001(sop), AAAAAA0F, FFFFFFFF(eop), out_accept=1.
  - Response: out_header=128'h00000000_FFFFFFFF_AAAAAA0F_048FC001, has_payload=0, 4dw=0, out_payload=0, one out_valid cycle.
- MWr 3DW, len 2:
  - Stimulus: 40000002(sop), 0000000F, 10000000, 11111111, 22222222(eop).
  - Response: out_payload=11111111, has_payload=1, out_valid one cycle after eop.
- MRd 4DW:
  - Stimulus: 20000001(sop), 0000000F, 00000001, 80000000(eop).
  - Response: out_hdr_4dw=1, out_header[127:96]=80000000.
- Malformed:
  - Stimulus: MRd 3DW with eop on DW1.
  - Response: err_malformed pulses once, drop_count=1, no out_valid. A following valid CfgRd0 is delivered normally.
- Backpressure:
  - Stimulus: hold out_accept=0 for 5 cycles after a descriptor appears.
  - Response: rx_ready=0 and out_* constant throughout; accept on cycle 6 gives out_valid=0 and rx_ready=1 next cycle.
- Reset mid-DRAIN:
  - Stimulus: assert rst_n=0 for one cycle while in DRAIN.
  - Response: all outputs 0, drop_count=0, next sop packet assembled correctly.

Source files
------------

// File: rtl/tlp_header_assembler.sv
// Gathers each received TLP's 3DW/4DW header and first payload DW into one descriptor,
// drops packets whose framing disagrees with fmt/length, and stalls the stream until the descriptor is taken.
module tlp_header_assembler #(
  parameter int          DROP_CNT_WIDTH = 8,
  parameter logic [31:0] PAD_DW         = 32'h00000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               rx_data,
  input  logic                      rx_valid,
  input  logic                      rx_sop,
  input  logic                      rx_eop,
  output logic                      rx_ready,
  output logic [127:0]              out_header,
  output logic [31:0]               out_payload,
  output logic                      out_has_payload,
  output logic                      out_hdr_4dw,
  output logic                      out_valid,
  input  logic                      out_accept,
  output logic                      err_malformed,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);
  typedef enum logic [2:0] {IDLE, HDR, PAY, DRAIN, HOLD} state_t;

  state_t                    state_reg, state_next;
  logic [1:0]                dw_idx_reg, dw_idx_next;
  logic [10:0]               len_reg;
  logic [10:0]               remain_reg, remain_next;
  logic                      discard_reg, discard_next;
  logic                      ready_reg;
  logic [31:0]               payload_reg;
  logic                      err_reg;
  logic [DROP_CNT_WIDTH-1:0] drop_reg;

  logic xfer;
  logic start;
  logic hdr_we;
  logic pay_we;
  logic err;
  logic last_hdr;
  logic sop_restart;

  assign xfer     = rx_valid && ready_reg;
  assign last_hdr = (dw_idx_reg == (out_hdr_4dw ? 2'd3 : 2'd2));
  // A sop seen while discarding the tail of a bad packet is part of that tail.
  assign sop_restart = xfer && rx_sop && (state_reg != HOLD) &&
                       !((state_reg == IDLE) && discard_reg);

  always_comb begin
    state_next   = state_reg;
    dw_idx_next  = dw_idx_reg;
    remain_next  = remain_reg;
    discard_next = discard_reg;
    start        = 1'b0;
    hdr_we       = 1'b0;
    pay_we       = 1'b0;
    err          = 1'b0;
    if (sop_restart) begin
      start        = 1'b1;
      discard_next = 1'b0;
      dw_idx_next  = 2'd1;
      err          = (state_reg != IDLE) || rx_eop;
      state_next   = rx_eop ? IDLE : HDR;
    end else begin
      case (state_reg)
        IDLE: begin
          if (xfer && discard_reg && rx_eop) discard_next = 1'b0;
        end
        HDR: begin
          if (xfer) begin
            hdr_we = 1'b1;
            if (!last_hdr) begin
              dw_idx_next = dw_idx_reg + 2'd1;
              if (rx_eop) begin
                err        = 1'b1;
                state_next = IDLE;
              end
            end else if (out_has_payload) begin
              if (rx_eop) begin
                err        = 1'b1;
                state_next = IDLE;
              end else begin
                state_next = PAY;
              end
            end else if (rx_eop) begin
              state_next = HOLD;
            end else begin
              err          = 1'b1;
              state_next   = IDLE;
              discard_next = 1'b1;
            end
          end
        end
        PAY: begin
          if (xfer) begin
            pay_we = 1'b1;
            if (len_reg == 11'd1) begin
              if (rx_eop) begin
                state_next = HOLD;
              end else begin
                err          = 1'b1;
                state_next   = IDLE;
                discard_next = 1'b1;
              end
            end else if (rx_eop) begin
              err        = 1'b1;
              state_next = IDLE;
            end else begin
              state_next  = DRAIN;
              remain_next = len_reg - 11'd1;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            remain_next = remain_reg - 11'd1;
            if (remain_reg == 11'd1) begin
              if (rx_eop) begin
                state_next = HOLD;
              end else begin
                err          = 1'b1;
                state_next   = IDLE;
                discard_next = 1'b1;
              end
            end else if (rx_eop) begin
              err        = 1'b1;
              state_next = IDLE;
            end
          end
        end
        HOLD: begin
          if (out_accept) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      dw_idx_reg  <= 2'd0;
      len_reg     <= 11'd0;
      remain_reg  <= 11'd0;
      discard_reg <= 1'b0;
      ready_reg   <= 1'b0;
      err_reg     <= 1'b0;
      drop_reg    <= '0;
      payload_reg <= 32'h0;
    end else begin
      state_reg   <= state_next;
      dw_idx_reg  <= dw_idx_next;
      remain_reg  <= remain_next;
      discard_reg <= discard_next;
      ready_reg   <= (state_next != HOLD);
      err_reg     <= err;
      // A zero length field encodes 1024 DWs.
      if (start) len_reg <= {(rx_data[9:0] == 10'd0), rx_data[9:0]};
      if (err && !(&drop_reg)) drop_reg <= drop_reg + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
      if (start) payload_reg <= PAD_DW;
      else if (pay_we) payload_reg <= rx_data;
    end
  end

  // Header slots: reloaded on every sop so nothing from a previous packet survives.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    logic [31:0] slot_reg;
    logic [31:0] slot_init;
    if (gi == 0) begin : g_dw0
      assign slot_init = rx_data;
    end else if (gi == 3) begin : g_dw3
      assign slot_init = rx_data[29] ? 32'h0 : PAD_DW;
    end else begin : g_mid
      assign slot_init = 32'h0;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) slot_reg <= 32'h0;
      else if (start) slot_reg <= slot_init;
      else if (hdr_we && (dw_idx_reg == 2'(gi))) slot_reg <= rx_data;
    end
    assign out_header[gi*32 +: 32] = slot_reg;
  end

  assign out_has_payload = out_header[30];
  assign out_hdr_4dw     = out_header[29];
  assign out_payload     = payload_reg;
  assign out_valid       = (state_reg == HOLD);
  assign rx_ready        = ready_reg;
  assign err_malformed   = err_reg;
  assign drop_count      = drop_reg;
endmodule

// File: tb/tb_tlp_header_assembler.sv
// Bench for tlp_header_assembler: directed vector table, hand-written corner sequences,
// then random packets scored against a packet-level model.
module tb_tlp_header_assembler;
  localparam int          DCW = 8;
  localparam logic [31:0] PAD = 32'h00000000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [31:0]    rx_data = 32'h0;
  logic           rx_valid = 1'b0;
  logic           rx_sop = 1'b0;
  logic           rx_eop = 1'b0;
  logic           rx_ready;
  logic [127:0]   out_header;
  logic [31:0]    out_payload;
  logic           out_has_payload;
  logic           out_hdr_4dw;
  logic           out_valid;
  logic           out_accept = 1'b0;
  logic           err_malformed;
  logic [DCW-1:0] drop_count;

  tlp_header_assembler #(.DROP_CNT_WIDTH(DCW), .PAD_DW(PAD)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_ready(rx_ready),
    .out_header(out_header), .out_payload(out_payload),
    .out_has_payload(out_has_payload), .out_hdr_4dw(out_hdr_4dw),
    .out_valid(out_valid), .out_accept(out_accept),
    .err_malformed(err_malformed), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  dw [6];
    int           n;
    bit           ok;
    logic [127:0] hdr;
    logic [31:0]  pay;
    bit           has;
    bit           is4;
  } vec_t;

  typedef struct {
    logic [127:0] hdr;
    logic [31:0]  pay;
    bit           has;
    bit           is4;
  } desc_t;

  vec_t  vec [8];
  desc_t exp_q [$];
  desc_t mon_e;
  int    tests = 0;
  int    fails = 0;
  int    err_cnt = 0;
  bit    rand_mode = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic put(input int i, input int n, input logic [31:0] d0, d1, d2, d3, d4, d5,
                     input bit ok, input logic [127:0] h, input logic [31:0] p,
                     input bit has, input bit is4);
    vec[i].dw  = '{d0, d1, d2, d3, d4, d5};
    vec[i].n   = n;
    vec[i].ok  = ok;
    vec[i].hdr = h;
    vec[i].pay = p;
    vec[i].has = has;
    vec[i].is4 = is4;
  endtask

  // Drive one DW and return #1 after the edge that transferred it.
  task automatic send_dw(input logic [31:0] d, input logic s, input logic e);
    int guard;
    guard = 0;
    rx_data = d; rx_sop = s; rx_eop = e; rx_valid = 1'b1;
    while (!rx_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) begin
      tests++; fails++;
      $display("FAIL send_timeout: rx_ready stayed %b, required 1", rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] dws[$], input bit gaps);
    for (int i = 0; i < dws.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_dw(dws[i], (i == 0), (i == dws.size() - 1));
    end
  endtask

  always @(negedge clk) if (err_malformed) err_cnt++;

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_accept = ($urandom_range(0, 2) != 0);
    end
  end

  // Random-phase scoreboard: every accepted descriptor must match the oldest expected one.
  always @(negedge clk) begin
    if (rand_mode && out_valid && out_accept) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rnd_unexpected: got descriptor %h, required none", out_header);
      end else begin
        mon_e = exp_q.pop_front();
        check("rnd_header", out_header, mon_e.hdr);
        check("rnd_payload", out_payload, mon_e.pay);
        check("rnd_has_payload", out_has_payload, mon_e.has);
        check("rnd_hdr_4dw", out_hdr_4dw, mon_e.is4);
      end
    end
  end

  initial begin
    logic [31:0] q [$];
    logic [31:0] dw0;
    desc_t       e;
    int          len, hdr_n, exp_n, n, kind, exp_drops, err_base;

    put(0, 3, 32'h048FC001, 32'hAAAAAA0F, 32'hFFFFFFFF, 0, 0, 0,
        1, 128'h00000000_FFFFFFFF_AAAAAA0F_048FC001, 32'h0, 0, 0);
    put(1, 5, 32'h40000002, 32'h0000000F, 32'h10000000, 32'h11111111, 32'h22222222, 0,
        1, 128'h00000000_10000000_0000000F_40000002, 32'h11111111, 1, 0);
    put(2, 4, 32'h20000001, 32'h0000000F, 32'h00000001, 32'h80000000, 0, 0,
        1, 128'h80000000_00000001_0000000F_20000001, 32'h0, 0, 1);
    put(3, 2, 32'h00000001, 32'h0000000F, 0, 0, 0, 0, 0, 128'h0, 32'h0, 0, 0);
    put(4, 3, 32'h048FC001, 32'hBBBB0010, 32'h12345678, 0, 0, 0,
        1, 128'h00000000_12345678_BBBB0010_048FC001, 32'h0, 0, 0);
    put(5, 5, 32'h60000001, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D, 0,
        1, 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_60000001, 32'h0D0D0D0D, 1, 1);
    put(6, 4, 32'h00000001, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0,
        0, 128'h0, 32'h0, 0, 0);
    put(7, 6, 32'h40000003, 32'h0000000F, 32'h20000000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003,
        1, 128'h00000000_20000000_0000000F_40000003, 32'hCAFE0001, 1, 0);

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_header", out_header, 0);
    check("rst_out_payload", out_payload, 0);
    check("rst_flags", {out_has_payload, out_hdr_4dw, err_malformed}, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_rx_ready", rx_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_rx_ready", rx_ready, 1);

    // Directed vector table
    out_accept = 1'b1;
    err_base = err_cnt;
    exp_drops = 0;
    for (int i = 0; i < 8; i++) begin
      q.delete();
      for (int k = 0; k < vec[i].n; k++) q.push_back(vec[i].dw[k]);
      send_pkt(q, 0);
      check($sformatf("vec%0d_valid", i), out_valid, vec[i].ok);
      if (vec[i].ok) begin
        check($sformatf("vec%0d_header", i), out_header, vec[i].hdr);
        check($sformatf("vec%0d_payload", i), out_payload, vec[i].pay);
        check($sformatf("vec%0d_has_payload", i), out_has_payload, vec[i].has);
        check($sformatf("vec%0d_hdr_4dw", i), out_hdr_4dw, vec[i].is4);
        @(posedge clk); #1;
        check($sformatf("vec%0d_valid_one_cycle", i), out_valid, 0);
      end else begin
        exp_drops++;
      end
    end
    @(posedge clk); #1;
    check("vec_err_pulses", err_cnt - err_base, exp_drops);
    check("vec_drop_count", drop_count, exp_drops);

    // Backpressure: five stalled cycles, accept on the sixth
    out_accept = 1'b0;
    q.delete();
    for (int k = 0; k < vec[0].n; k++) q.push_back(vec[0].dw[k]);
    send_pkt(q, 0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_rx_ready", c), rx_ready, 0);
      check($sformatf("bp%0d_out_valid", c), out_valid, 1);
      check($sformatf("bp%0d_header", c), out_header, vec[0].hdr);
      @(posedge clk); #1;
    end
    out_accept = 1'b1;
    check("bp_accept_valid", out_valid, 1);
    @(posedge clk); #1;
    check("bp_after_valid", out_valid, 0);
    check("bp_after_rx_ready", rx_ready, 1);

    // Reset while draining a payload
    send_dw(32'h40000004, 1, 0);
    send_dw(32'h00000001, 0, 0);
    send_dw(32'h00000002, 0, 0);
    send_dw(32'h55550000, 0, 0);
    send_dw(32'h55550001, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_header", out_header, 0);
    check("mrst_out_payload", out_payload, 0);
    check("mrst_flags", {out_has_payload, out_hdr_4dw, err_malformed}, 0);
    check("mrst_drop_count", drop_count, 0);
    check("mrst_rx_ready", rx_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_release_rx_ready", rx_ready, 1);
    q.delete();
    for (int k = 0; k < vec[4].n; k++) q.push_back(vec[4].dw[k]);
    send_pkt(q, 0);
    check("mrst_pkt_valid", out_valid, 1);
    check("mrst_pkt_header", out_header, vec[4].hdr);
    @(posedge clk); #1;

    // Random packets against the packet-level model
    err_base = err_cnt;
    exp_drops = 0;
    rand_mode = 1'b1;
    for (int p = 0; p < 80; p++) begin
      dw0 = $urandom;
      if ($urandom_range(0, 24) == 0) dw0[9:0] = 10'd0;
      else dw0[9:0] = 10'($urandom_range(1, 6));
      len   = (dw0[9:0] == 10'd0) ? 1024 : int'(dw0[9:0]);
      hdr_n = dw0[29] ? 4 : 3;
      exp_n = hdr_n + (dw0[30] ? len : 0);
      kind  = $urandom_range(0, 7);
      n     = exp_n;
      if (kind == 0) n = $urandom_range(1, exp_n - 1);
      else if (kind == 1) n = exp_n + $urandom_range(1, 3);
      q.delete();
      q.push_back(dw0);
      for (int k = 1; k < n; k++) q.push_back($urandom);
      if (n == exp_n) begin
        e.hdr = {PAD, q[2], q[1], q[0]};
        if (dw0[29]) e.hdr[127:96] = q[3];
        e.pay = dw0[30] ? q[hdr_n] : PAD;
        e.has = dw0[30];
        e.is4 = dw0[29];
        exp_q.push_back(e);
      end else begin
        exp_drops++;
      end
      send_pkt(q, 1);
    end
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
    rand_mode = 1'b0;
    #2;
    out_accept = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rnd_all_delivered", exp_q.size(), 0);
    check("rnd_err_pulses", err_cnt - err_base, exp_drops);
    check("rnd_drop_count", drop_count, (exp_drops > 255) ? 255 : exp_drops);
    check("rnd_end_idle", {out_valid, rx_ready}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
